// File: rtl/sram_pkg.sv
// Shared types and helpers for the two-port SRAM model: FSM states, mask-lane
// count and the lane merge used by both the write path and the write bypass.
package sram_pkg;

    localparam int unsigned MAX_DATA_WIDTH = 512;
    localparam int unsigned IDX_WIDTH      = $clog2(MAX_DATA_WIDTH);

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } init_state_t;

    function automatic int unsigned num_wmasks(input int unsigned data_width,
                                               input int unsigned wmask_width);
        return data_width / wmask_width;
    endfunction

    // Lanes whose mask bit is set come from new_word, the rest from old_word.
    function automatic logic [MAX_DATA_WIDTH-1:0] merge_lanes(
        input logic [MAX_DATA_WIDTH-1:0] old_word,
        input logic [MAX_DATA_WIDTH-1:0] new_word,
        input logic [MAX_DATA_WIDTH-1:0] mask,
        input int unsigned               lane_width
    );
        logic [MAX_DATA_WIDTH-1:0] merged;
        merged = old_word;
        for (int unsigned i = 0; i < MAX_DATA_WIDTH; i++) begin
            if (mask[IDX_WIDTH'(i / lane_width)]) begin
                merged[IDX_WIDTH'(i)] = new_word[IDX_WIDTH'(i)];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/sram_init_seq.sv
// Zero-initialisation sequencer: walks every address once after reset, then
// parks in READY until the next reset.
module sram_init_seq
    import sram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  init_we_c,
    output logic [ADDR_WIDTH-1:0] init_addr,
    output logic                  init_done
);

    init_state_t state;

    assign init_we_c = (state == INIT);

    // Last address written moves to READY and raises init_done on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= INIT;
            init_addr <= '0;
            init_done <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    if (&init_addr) begin
                        state     <= READY;
                        init_done <= 1'b1;
                    end else begin
                        init_addr <= init_addr + ADDR_WIDTH'(1);
                    end
                end
                default: state <= READY;
            endcase
        end
    end

endmodule

// File: rtl/sram_1rw1r_param.sv
// Parametrised 1RW + 1R SRAM model with lane write mask, hardware zero-init and
// flagged same-address collisions. Define SRAM_WRITE_BYPASS_EN to make a colliding
// port 1 read return the write-through word instead of the pre-write word.
module sram_1rw1r_param
    import sram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 8,
    parameter int unsigned WMASK_WIDTH  = 8,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                                         clk0,
    input  logic                                         rst0,
    input  logic                                         csb0,
    input  logic                                         web0,
    input  logic [num_wmasks(DATA_WIDTH, WMASK_WIDTH)-1:0] wmask0,
    input  logic [ADDR_WIDTH-1:0]                        addr0,
    input  logic [DATA_WIDTH-1:0]                        din0,
    output logic [DATA_WIDTH-1:0]                        dout0,
    output logic                                         dvalid0,
    input  logic                                         csb1,
    input  logic [ADDR_WIDTH-1:0]                        addr1,
    output logic [DATA_WIDTH-1:0]                        dout1,
    output logic                                         dvalid1,
    output logic                                         collision1,
    output logic                                         init_done
);

    localparam int unsigned RAM_DEPTH  = 1 << ADDR_WIDTH;
    localparam int unsigned NUM_WMASKS = num_wmasks(DATA_WIDTH, WMASK_WIDTH);

    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("sram_1rw1r_param: READ_LATENCY must be 1 or 2");
    end
    if (WMASK_WIDTH == 0 || NUM_WMASKS * WMASK_WIDTH != DATA_WIDTH
        || DATA_WIDTH > MAX_DATA_WIDTH) begin : g_bad_width
        $error("sram_1rw1r_param: DATA_WIDTH must be a multiple of WMASK_WIDTH and fit MAX_DATA_WIDTH");
    end

    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

    logic                  init_we_c;
    logic [ADDR_WIDTH-1:0] init_addr;

    sram_init_seq #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_init_seq (
        .clk       (clk0),
        .rst       (rst0),
        .init_we_c (init_we_c),
        .init_addr (init_addr),
        .init_done (init_done)
    );

    logic                  rd0_c;
    logic                  wr0_c;
    logic                  rd1_c;
    logic                  col1_c;
    logic [DATA_WIDTH-1:0] wr_word_c;
    logic [DATA_WIDTH-1:0] rd0_word_c;
    logic [DATA_WIDTH-1:0] rd1_word_c;

    // Requests only count once the array has been zeroed.
    always_comb begin
        rd0_c      = init_done & ~csb0 & web0;
        wr0_c      = init_done & ~csb0 & ~web0;
        rd1_c      = init_done & ~csb1;
        col1_c     = wr0_c & rd1_c & (addr0 == addr1);
        wr_word_c  = DATA_WIDTH'(merge_lanes(MAX_DATA_WIDTH'(mem[addr0]), MAX_DATA_WIDTH'(din0),
                                             MAX_DATA_WIDTH'(wmask0), WMASK_WIDTH));
        rd0_word_c = mem[addr0];
        rd1_word_c = mem[addr1];
`ifdef SRAM_WRITE_BYPASS_EN
        if (col1_c) begin
            rd1_word_c = wr_word_c;
        end
`endif
    end

    // Single write port into the array, shared between init and port 0.
    always_ff @(posedge clk0) begin
        if (init_we_c) begin
            mem[init_addr] <= '0;
        end else if (wr0_c) begin
            mem[addr0] <= wr_word_c;
        end
    end

    logic                  src_v0_c;
    logic                  src_v1_c;
    logic                  src_col1_c;
    logic [DATA_WIDTH-1:0] src_d0_c;
    logic [DATA_WIDTH-1:0] src_d1_c;

    if (READ_LATENCY == 2) begin : g_lat2
        logic                  s1_v0;
        logic                  s1_v1;
        logic                  s1_col1;
        logic [DATA_WIDTH-1:0] s1_d0;
        logic [DATA_WIDTH-1:0] s1_d1;

        always_ff @(posedge clk0 or posedge rst0) begin
            if (rst0) begin
                s1_v0   <= 1'b0;
                s1_v1   <= 1'b0;
                s1_col1 <= 1'b0;
                s1_d0   <= '0;
                s1_d1   <= '0;
            end else begin
                s1_v0   <= rd0_c;
                s1_v1   <= rd1_c;
                s1_col1 <= col1_c;
                if (rd0_c) s1_d0 <= rd0_word_c;
                if (rd1_c) s1_d1 <= rd1_word_c;
            end
        end

        assign src_v0_c   = s1_v0;
        assign src_v1_c   = s1_v1;
        assign src_col1_c = s1_col1;
        assign src_d0_c   = s1_d0;
        assign src_d1_c   = s1_d1;
    end else begin : g_lat1
        assign src_v0_c   = rd0_c;
        assign src_v1_c   = rd1_c;
        assign src_col1_c = col1_c;
        assign src_d0_c   = rd0_word_c;
        assign src_d1_c   = rd1_word_c;
    end

    // Output stage: data holds between reads, valid/collision pulse for one cycle.
    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            dout0      <= '0;
            dout1      <= '0;
            dvalid0    <= 1'b0;
            dvalid1    <= 1'b0;
            collision1 <= 1'b0;
        end else begin
            dvalid0    <= src_v0_c;
            dvalid1    <= src_v1_c;
            collision1 <= src_col1_c;
            if (src_v0_c) dout0 <= src_d0_c;
            if (src_v1_c) dout1 <= src_d1_c;
        end
    end

endmodule
